// File: rtl/ex_fwd_wb.sv
// ex_fwd_wb: EX/MEM and MEM/WB result slots, load merge, operand forwarding.
// Optional stats counters are built when EX_FWD_STATS_EN is defined.
module ex_fwd_wb #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_BITS   = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ex_valid,
  input  logic [DATA_WIDTH-1:0] ex_result,
  input  logic [REG_BITS-1:0]   ex_dest_reg,
  input  logic                  ex_dest_reg_valid,
  input  logic                  ex_inval_dest_reg,
  input  logic                  ex_is_load,
  output logic                  ex_ready,
  input  logic [DATA_WIDTH-1:0] mem_load_data,
  input  logic                  mem_load_valid,
  input  logic                  stall_in,
  input  logic [REG_BITS-1:0]   a_reg,
  input  logic [REG_BITS-1:0]   b_reg,
  input  logic [DATA_WIDTH-1:0] a_rf_val,
  input  logic [DATA_WIDTH-1:0] b_rf_val,
  output logic [DATA_WIDTH-1:0] a_fwd_val,
  output logic [DATA_WIDTH-1:0] b_fwd_val,
  output logic                  load_use_stall,
  output logic                  mem_wait,
  output logic                  wb_en,
  output logic [REG_BITS-1:0]   wb_reg,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic [31:0]           fwd_hits,
  output logic [31:0]           lu_stalls
);

  typedef struct packed {
    logic                  valid;
    logic                  load;
    logic [REG_BITS-1:0]   dest;
    logic [DATA_WIDTH-1:0] result;
  } ex_mem_t;

  typedef struct packed {
    logic                  valid;
    logic [REG_BITS-1:0]   dest;
    logic [DATA_WIDTH-1:0] data;
  } mem_wb_t;

  ex_mem_t s1_q, s1_d, ex_entry;
  mem_wb_t s2_q, s2_d;

  logic pend;
  logic advance;
  logic capture;

  logic [REG_BITS-1:0]   op_reg [2];
  logic [DATA_WIDTH-1:0] op_rf  [2];
  logic [DATA_WIDTH-1:0] op_val [2];
  logic                  op_lu  [2];
  logic                  op_hit [2];

  // Qualify the incoming EX instruction; anything not writing a real reg is a bubble
  always_comb begin
    ex_entry = '0;
    if (ex_valid && ex_dest_reg_valid &&
        !ex_inval_dest_reg && (ex_dest_reg != '0)) begin
      ex_entry.valid  = 1'b1;
      ex_entry.load   = ex_is_load;
      ex_entry.dest   = ex_dest_reg;
      ex_entry.result = ex_result;
    end
  end

  assign pend     = s1_q.valid & s1_q.load & ~mem_load_valid;
  assign advance  = ~stall_in & ~pend;
  assign capture  = stall_in & s1_q.valid & s1_q.load & mem_load_valid;
  assign ex_ready = advance;
  assign mem_wait = pend;

  // Next-state for both slots: shift on advance, else hold S1 and bubble S2
  always_comb begin
    s1_d = s1_q;
    s2_d = '0;
    if (advance) begin
      s1_d = ex_entry;
      if (s1_q.valid) begin
        s2_d.valid = 1'b1;
        s2_d.dest  = s1_q.dest;
        s2_d.data  = s1_q.load ? mem_load_data : s1_q.result;
      end
    end else if (capture) begin
      s1_d.result = mem_load_data;
      s1_d.load   = 1'b0;
    end
  end

  // Slot registers
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign wb_en   = s2_q.valid;
  assign wb_reg  = s2_q.dest;
  assign wb_data = s2_q.data;

  assign op_reg[0] = a_reg;
  assign op_reg[1] = b_reg;
  assign op_rf[0]  = a_rf_val;
  assign op_rf[1]  = b_rf_val;

  // Per-operand forwarding; younger S1 masks S2, r0 always reads zero
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      logic zr, m1, m2;
      zr = (op_reg[i] == '0);
      m1 = ~zr & s1_q.valid & (s1_q.dest == op_reg[i]);
      m2 = ~zr & ~m1 & s2_q.valid & (s2_q.dest == op_reg[i]);
      op_val[i] = op_rf[i];
      op_lu[i]  = 1'b0;
      op_hit[i] = 1'b0;
      unique case (1'b1)
        zr: op_val[i] = '0;
        m1 & ~s1_q.load: begin
          op_val[i] = s1_q.result;
          op_hit[i] = 1'b1;
        end
        m1 & s1_q.load: op_lu[i] = 1'b1;
        m2: begin
          op_val[i] = s2_q.data;
          op_hit[i] = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign a_fwd_val      = op_val[0];
  assign b_fwd_val      = op_val[1];
  assign load_use_stall = op_lu[0] | op_lu[1];

`ifdef EX_FWD_STATS_EN
  logic [31:0] fwd_q;
  logic [31:0] lus_q;
  logic [1:0]  nhit;
  logic [32:0] fsum;

  assign nhit = {1'b0, op_hit[0]} + {1'b0, op_hit[1]};
  assign fsum = {1'b0, fwd_q} + {31'd0, nhit};

  // Saturating statistics counters
  always_ff @(posedge clock) begin
    if (reset) begin
      fwd_q <= '0;
      lus_q <= '0;
    end else begin
      if (ex_ready)
        fwd_q <= fsum[32] ? '1 : fsum[31:0];
      if (load_use_stall && (lus_q != '1))
        lus_q <= lus_q + 32'd1;
    end
  end

  assign fwd_hits  = fwd_q;
  assign lu_stalls = lus_q;
`else
  logic stats_unused;
  assign stats_unused = op_hit[0] ^ op_hit[1];
  assign fwd_hits     = '0;
  assign lu_stalls    = '0;
`endif

endmodule

// File: tb/tb_ex_fwd_wb.sv
// tb_ex_fwd_wb: directed bench for ex_fwd_wb with an age-ordered model.
// Counter checks follow EX_FWD_STATS_EN when defined.
module tb_ex_fwd_wb;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ex_valid = 1'b0;
  logic [31:0] ex_result = '0;
  logic [4:0]  ex_dest_reg = '0;
  logic        ex_dest_reg_valid = 1'b0;
  logic        ex_inval_dest_reg = 1'b0;
  logic        ex_is_load = 1'b0;
  logic        ex_ready;
  logic [31:0] mem_load_data = '0;
  logic        mem_load_valid = 1'b0;
  logic        stall_in = 1'b0;
  logic [4:0]  a_reg = '0;
  logic [4:0]  b_reg = '0;
  logic [31:0] a_rf_val = '0;
  logic [31:0] b_rf_val = '0;
  logic [31:0] a_fwd_val;
  logic [31:0] b_fwd_val;
  logic        load_use_stall;
  logic        mem_wait;
  logic        wb_en;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic [31:0] fwd_hits;
  logic [31:0] lu_stalls;

  ex_fwd_wb #(.DATA_WIDTH(32), .REG_BITS(5)) dut (
    .clock(clock), .reset(reset),
    .ex_valid(ex_valid), .ex_result(ex_result),
    .ex_dest_reg(ex_dest_reg),
    .ex_dest_reg_valid(ex_dest_reg_valid),
    .ex_inval_dest_reg(ex_inval_dest_reg),
    .ex_is_load(ex_is_load), .ex_ready(ex_ready),
    .mem_load_data(mem_load_data),
    .mem_load_valid(mem_load_valid),
    .stall_in(stall_in),
    .a_reg(a_reg), .b_reg(b_reg),
    .a_rf_val(a_rf_val), .b_rf_val(b_rf_val),
    .a_fwd_val(a_fwd_val), .b_fwd_val(b_fwd_val),
    .load_use_stall(load_use_stall),
    .mem_wait(mem_wait),
    .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
    .fwd_hits(fwd_hits), .lu_stalls(lu_stalls)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: in-flight results ordered by age, index 0 youngest
  typedef struct {
    bit        v;
    bit        ld;
    bit [4:0]  r;
    bit [31:0] d;
  } ment_t;

  ment_t  pipe [2];
  bit     armed = 1'b0;
  longint m_fh = 0;
  longint m_lu = 0;
  int     wb_cnt [32];

  function automatic void lookup(input logic [4:0] r,
                                 input logic [31:0] rf,
                                 output logic [31:0] v,
                                 output bit lu, output bit hit);
    bit done;
    done = 1'b0;
    v = rf;
    lu = 1'b0;
    hit = 1'b0;
    if (r == 5'd0) begin
      v = '0;
      done = 1'b1;
    end
    for (int k = 0; k < 2; k++) begin
      if (!done && pipe[k].v && pipe[k].r == r) begin
        done = 1'b1;
        if (pipe[k].ld) lu = 1'b1;
        else begin
          v = pipe[k].d;
          hit = 1'b1;
        end
      end
    end
  endfunction

  always @(posedge clock) begin : model_b
    ment_t nw;
    logic [31:0] va, vb;
    bit la, lb, ha, hb, pend;
    if (reset) begin
      pipe[0] = '{default: 0};
      pipe[1] = '{default: 0};
      m_fh = 0;
      m_lu = 0;
      armed = 1'b1;
    end else if (armed) begin
      pend = pipe[0].v && pipe[0].ld && !mem_load_valid;
      lookup(a_reg, a_rf_val, va, la, ha);
      lookup(b_reg, b_rf_val, vb, lb, hb);
      if (!stall_in && !pend) begin
        m_fh = m_fh + longint'(ha) + longint'(hb);
        if (m_fh > 64'hFFFFFFFF) m_fh = 64'hFFFFFFFF;
      end
      if (la || lb) begin
        m_lu = m_lu + 1;
        if (m_lu > 64'hFFFFFFFF) m_lu = 64'hFFFFFFFF;
      end
      nw.v  = ex_valid && ex_dest_reg_valid &&
              !ex_inval_dest_reg && ex_dest_reg != 5'd0;
      nw.ld = ex_is_load;
      nw.r  = ex_dest_reg;
      nw.d  = ex_result;
      if (!stall_in && !pend) begin
        pipe[1] = pipe[0];
        if (pipe[1].ld) pipe[1].d = mem_load_data;
        pipe[1].ld = 1'b0;
        pipe[0] = nw;
      end else begin
        if (pipe[0].ld && mem_load_valid) begin
          pipe[0].d  = mem_load_data;
          pipe[0].ld = 1'b0;
        end
        pipe[1].v = 1'b0;
      end
    end
  end

  // Compare every cycle once the model has seen reset
  always @(negedge clock) begin : cmp_b
    logic [31:0] va, vb;
    bit la, lb, ha, hb, pend;
    if (armed) begin
      pend = pipe[0].v && pipe[0].ld && !mem_load_valid;
      lookup(a_reg, a_rf_val, va, la, ha);
      lookup(b_reg, b_rf_val, vb, lb, hb);
      chk("ex_ready", 32'(ex_ready), 32'(!stall_in && !pend));
      chk("mem_wait", 32'(mem_wait), 32'(pend));
      chk("load_use_stall", 32'(load_use_stall), 32'(la || lb));
      chk("wb_en", 32'(wb_en), 32'(pipe[1].v));
      if (pipe[1].v) begin
        chk("wb_reg", 32'(wb_reg), 32'(pipe[1].r));
        chk("wb_data", wb_data, pipe[1].d);
      end
      if (!la) chk("a_fwd_val", a_fwd_val, va);
      if (!lb) chk("b_fwd_val", b_fwd_val, vb);
`ifdef EX_FWD_STATS_EN
      chk("fwd_hits", fwd_hits, m_fh[31:0]);
      chk("lu_stalls", lu_stalls, m_lu[31:0]);
`else
      chk("fwd_hits", fwd_hits, 32'd0);
      chk("lu_stalls", lu_stalls, 32'd0);
`endif
      if (wb_en === 1'b1) wb_cnt[wb_reg]++;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ex(input logic [4:0] r, input logic [31:0] d,
                    input bit ld, input bit inval);
    ex_valid = 1'b1;
    ex_dest_reg_valid = 1'b1;
    ex_dest_reg = r;
    ex_result = d;
    ex_is_load = ld;
    ex_inval_dest_reg = inval;
  endtask

  task automatic idle();
    ex_valid = 1'b0;
    ex_dest_reg_valid = 1'b0;
    ex_inval_dest_reg = 1'b0;
    ex_is_load = 1'b0;
    ex_dest_reg = '0;
    ex_result = '0;
  endtask

  task automatic flush();
    idle();
    stall_in = 1'b0;
    mem_load_valid = 1'b0;
    a_reg = '0;
    b_reg = '0;
    tick();
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    foreach (wb_cnt[i]) wb_cnt[i] = 0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    @(negedge clock);
    chk("rst_wb_en", 32'(wb_en), 32'd0);
    chk("rst_wb_reg", 32'(wb_reg), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_ex_ready", 32'(ex_ready), 32'd1);
    chk("rst_mem_wait", 32'(mem_wait), 32'd0);
    chk("rst_lu", 32'(load_use_stall), 32'd0);
    chk("rst_fwd_hits", fwd_hits, 32'd0);
    chk("rst_lu_stalls", lu_stalls, 32'd0);
    tick();

    ex(5'd5, 32'h10, 1'b0, 1'b0);
    a_reg = 5'd5;
    a_rf_val = '0;
    tick();
    idle();
    @(negedge clock);
    chk("alu_s1_fwd", a_fwd_val, 32'h10);
    chk("alu_s1_nowb", 32'(wb_en), 32'd0);
    tick();
    @(negedge clock);
    chk("alu_s2_fwd", a_fwd_val, 32'h10);
    chk("alu_wb_en", 32'(wb_en), 32'd1);
    chk("alu_wb_reg", 32'(wb_reg), 32'd5);
    chk("alu_wb_data", wb_data, 32'h10);
    tick();
    flush();

    ex(5'd7, 32'h11, 1'b0, 1'b0);
    tick();
    ex(5'd7, 32'h22, 1'b0, 1'b0);
    tick();
    idle();
    b_reg = 5'd7;
    b_rf_val = 32'h99;
    @(negedge clock);
    chk("prio_s1_over_s2", b_fwd_val, 32'h22);
    tick();
    flush();

    ex(5'd0, 32'hFFFFFFFF, 1'b0, 1'b0);
    tick();
    ex(5'd3, 32'h33, 1'b0, 1'b1);
    tick();
    idle();
    a_reg = 5'd0;
    a_rf_val = 32'h5555;
    b_reg = 5'd3;
    b_rf_val = 32'h1234;
    @(negedge clock);
    chk("r0_zero", a_fwd_val, 32'd0);
    chk("movn_nofwd", b_fwd_val, 32'h1234);
    chk("r0_nowb", 32'(wb_en), 32'd0);
    tick();
    @(negedge clock);
    chk("movn_nowb", 32'(wb_en), 32'd0);
    tick();
    flush();

    ex(5'd9, 32'h1000, 1'b1, 1'b0);
    tick();
    idle();
    a_reg = 5'd9;
    a_rf_val = 32'h7;
    repeat (2) begin
      @(negedge clock);
      chk("lu_stall", 32'(load_use_stall), 32'd1);
      chk("lu_mem_wait", 32'(mem_wait), 32'd1);
      chk("lu_ex_ready", 32'(ex_ready), 32'd0);
      tick();
    end
    mem_load_valid = 1'b1;
    mem_load_data = 32'hCAFEBABE;
    @(negedge clock);
    chk("ld_arrive_wait", 32'(mem_wait), 32'd0);
    chk("ld_arrive_ready", 32'(ex_ready), 32'd1);
    tick();
    mem_load_valid = 1'b0;
    mem_load_data = '0;
    @(negedge clock);
    chk("ld_wb_en", 32'(wb_en), 32'd1);
    chk("ld_wb_reg", 32'(wb_reg), 32'd9);
    chk("ld_wb_data", wb_data, 32'hCAFEBABE);
    chk("ld_s2_fwd", a_fwd_val, 32'hCAFEBABE);
    tick();
    flush();

    ex(5'd4, 32'h44, 1'b0, 1'b0);
    tick();
    idle();
    stall_in = 1'b1;
    base = wb_cnt[4];
    repeat (3) begin
      @(negedge clock);
      chk("stall_ready", 32'(ex_ready), 32'd0);
      chk("stall_nowb", 32'(wb_en), 32'd0);
      tick();
    end
    stall_in = 1'b0;
    @(negedge clock);
    chk("stall_rel_ready", 32'(ex_ready), 32'd1);
    tick();
    @(negedge clock);
    chk("stall_wb_reg", 32'(wb_reg), 32'd4);
    chk("stall_wb_data", wb_data, 32'h44);
    tick();
    @(negedge clock);
    chk("stall_wb_done", 32'(wb_en), 32'd0);
    tick();
    chk("stall_wb_once", 32'(wb_cnt[4] - base), 32'd1);
    flush();

    ex(5'd10, 32'h2000, 1'b1, 1'b0);
    tick();
    idle();
    stall_in = 1'b1;
    mem_load_valid = 1'b1;
    mem_load_data = 32'hABCD0123;
    tick();
    mem_load_valid = 1'b0;
    mem_load_data = '0;
    @(negedge clock);
    chk("cap_nowait", 32'(mem_wait), 32'd0);
    chk("cap_stalled", 32'(ex_ready), 32'd0);
    tick();
    stall_in = 1'b0;
    @(negedge clock);
    chk("cap_ready", 32'(ex_ready), 32'd1);
    tick();
    @(negedge clock);
    chk("cap_wb_reg", 32'(wb_reg), 32'd10);
    chk("cap_wb_data", wb_data, 32'hABCD0123);
    tick();
    flush();

    for (int i = 0; i < 24; i++) begin
      ex_valid = 1'b1;
      ex_dest_reg_valid = (i % 6) != 5;
      ex_inval_dest_reg = (i % 8) == 7;
      ex_is_load = (i % 5) == 3;
      ex_dest_reg = 5'((i % 4) + 1);
      ex_result = 32'h100 * i + 32'h3;
      mem_load_valid = (i % 3) != 0;
      mem_load_data = 32'hD0000000 + 32'(i);
      stall_in = (i % 7) == 6;
      a_reg = 5'((i % 4) + 1);
      b_reg = 5'(((i + 2) % 4) + 1);
      a_rf_val = 32'hA000 + 32'(i);
      b_rf_val = 32'hB000 + 32'(i);
      tick();
    end
    mem_load_valid = 1'b1;
    flush();

    ex(5'd1, 32'h1, 1'b0, 1'b0);
    tick();
    ex(5'd2, 32'h2, 1'b0, 1'b0);
    tick();
    idle();
    reset = 1'b1;
    a_reg = 5'd1;
    a_rf_val = 32'hA1;
    b_reg = 5'd2;
    b_rf_val = 32'hB2;
    @(negedge clock);
    chk("pre_rst_a", a_fwd_val, 32'h1);
    chk("pre_rst_b", b_fwd_val, 32'h2);
    tick();
    reset = 1'b0;
    @(negedge clock);
    chk("mid_rst_nowb", 32'(wb_en), 32'd0);
    chk("mid_rst_a", a_fwd_val, 32'hA1);
    chk("mid_rst_b", b_fwd_val, 32'hB2);
    chk("mid_rst_fh", fwd_hits, 32'd0);
    chk("mid_rst_lus", lu_stalls, 32'd0);
    tick();
    flush();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_fwd_wb.md
Name: ex_fwd_wb

Overview:
- Downstream end of the execute stage. Captures each EX result (result, destination register, MOVZ/MOVN invalidate) into a two-entry post-EX result pipeline, S1 (EX/MEM) and S2 (MEM/WB).
- Merges load data into load entries, drives the register-file write port from S2, and supplies forwarded A/B operand values back to the decode/EX boundary.
- Raises load-use and memory-wait back-pressure toward the front of the pipe.

Parameters:
- DATA_WIDTH, 32, width of results, operands and load data.
- REG_BITS, 5, width of register indices.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ex_valid  in  1  EX presents an instruction this cycle
- ex_result  in  DATA_WIDTH  EX result
- ex_dest_reg  in  REG_BITS  destination register
- ex_dest_reg_valid  in  1  instruction writes a register
- ex_inval_dest_reg  in  1  MOVZ/MOVN condition failed; suppress write
- ex_is_load  in  1  result is an address; data comes from memory
- ex_ready  out  1  ex_* accepted at this clock edge
- mem_load_data  in  DATA_WIDTH  load data for the S1 load entry
- mem_load_valid  in  1  mem_load_data is valid this cycle
- stall_in  in  1  downstream/global hold
- a_reg, b_reg  in  REG_BITS each  operand register indices from decode
- a_rf_val, b_rf_val  in  DATA_WIDTH each  register-file read values
- a_fwd_val, b_fwd_val  out  DATA_WIDTH each  operand values after forwarding
- load_use_stall  out  1  an operand depends on an unresolved load in S1
- mem_wait  out  1  S1 load is waiting for data
- wb_en  out  1  register-file write enable
- wb_reg  out  REG_BITS  write index
- wb_data  out  DATA_WIDTH  write data
- fwd_hits  out  32  forward-hit count (see Optional Feature)
- lu_stalls  out  32  load-use stall cycle count (see Optional Feature)

Behaviour:
- One clock. Reset is synchronous and active-high. Clock port is clock; reset port is reset.
- Reset values:
  - S1 and S2 invalid.
  - wb_en=0, wb_reg=0, wb_data=0.
  - ex_ready=1, mem_wait=0, load_use_stall=0, counters=0.
  - Reset mid-operation discards all in-flight entries; no write occurs on the cycle after reset.
- Entry qualification: an entry is valid iff ex_valid & ex_dest_reg_valid & ~ex_inval_dest_reg & (ex_dest_reg!=0). Otherwise a bubble enters S1. Register 0 is never tracked.
- Load pending: pend = S1.valid & S1.load & ~mem_load_valid.
  - mem_wait = pend.
  - ex_ready = ~stall_in & ~pend (combinational).
- Advance on each clock edge:
  - stall_in=1: S1 holds; S2 takes a bubble.
  - pend=1 (stall_in=0): S1 holds; S2 takes a bubble.
  - Otherwise: S2 <= S1, with data = mem_load_data if S1.load else S1.result; S1 <= new EX entry.
- Writeback: wb_en, wb_reg, wb_data are driven combinationally from S2 register contents. Each S2 entry is therefore written exactly once; the 1-cycle S2 latency gives EX-to-RF latency of 2 clocks for ALU results.
- Forwarding, per operand, combinational. Priority is S1 > S2 > RF:
  - index 0 gives value 0.
  - S1.valid match and not a load gives S1.result.
  - S1.valid match and a load gives load_use_stall=1; value = a/b_rf_val (don't care).
  - S2.valid match gives S2.data.
  - otherwise rf value.
- A younger S1 match masks an older S2 match to the same register. An S1 invalidated by MOVZ/MOVN never forwards.
- load_use_stall is the OR over both operands. It is independent of stall_in.
- Simultaneous stall_in and pend: stall_in dominates; the S1 load may still capture data. While S1 holds, a load entry latches mem_load_data on the first cycle mem_load_valid=1 and clears pend.

Optional Feature:
- Macro: EX_FWD_STATS_EN.
- Defined:
  - fwd_hits increments by the number of operands (0-2) that were forwarded from S1/S2 on each cycle with ex_ready=1.
  - lu_stalls increments on each cycle load_use_stall=1.
  - Both saturate at 32'hFFFFFFFF and clear on reset.
- Undefined: both outputs are tied to 0 and no counter flops exist.

Test Plan:
- ALU back-to-back: EX add writes r5=0x00000010; next cycle a_reg=5, a_rf_val=0 -> a_fwd_val=0x10 (from S1). Following cycle -> 0x10 (from S2), wb_en=1, wb_reg=5, wb_data=0x10.
- Priority: r7=0x11 in S2 and r7=0x22 in S1, b_reg=7 -> b_fwd_val=0x22.
- Zero register and MOVN: dest r0 with result 0xFFFFFFFF, then MOVN with inval=1 to r3 -> a_fwd_val for a_reg=0 is 0, no forward for r3, no wb_en for either.
- Load-use: load to r9 in S1, a_reg=9, mem_load_valid=0 for 2 cycles -> load_use_stall=1, mem_wait=1, ex_ready=0 for 2 cycles. Then data 0xCAFEBABE arrives -> next cycle wb_data=0xCAFEBABE, wb_reg=9.
- stall_in: stall_in=1 for 3 cycles with S1 holding r4=0x44 -> a single wb of r4 only after release, ex_ready=0 throughout, no duplicate writes.
- Reset mid-flight: S1 and S2 both valid, assert reset one cycle -> next cycle wb_en=0, forwarding returns rf values. With EX_FWD_STATS_EN defined, counters read 0.
